pu_sequencer: RTL and testbench

//  Parametrised successor to the single power-up strobe + fixed slow-clock generator.

---
 rtl/pu_sequencer_pkg.sv | 21 ++
 rtl/pu_sequencer_if.sv | 28 ++
 rtl/pu_sequencer_lp_clk_div.sv | 48 ++++
 rtl/pu_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pu_sequencer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pu_sequencer_pkg.sv
// Shared types and defaults for the power-up sequencer.
//   state_t   : sequencer FSM encoding (2-bit)
//   clamp_dly : maps a step delay of 0 to 1 so a step never takes zero cycles
package pu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    ON   = 2'd2,
    DOWN = 2'd3
  } state_t;

  localparam int unsigned NUM_CH_DEFAULT = 4;
  localparam int unsigned DLY_W_DEFAULT  = 12;
  localparam int unsigned LP_DIV_DEFAULT = 13;

  function automatic logic [31:0] clamp_dly(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/pu_sequencer_if.sv
// Control/status bundle between the stimulus side and the power-up sequencer.
//   en_i, fault_i, step_dly : requests into the sequencer
//   pu_sig, pu_done, busy, fault_o, lp_clk, lp_tick : sequencer status
// master = side that issues requests, slave = the sequencer.
interface pu_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int DLY_W  = 12
);
  logic              en_i;
  logic              fault_i;
  logic [DLY_W-1:0]  step_dly;
  logic [NUM_CH-1:0] pu_sig;
  logic              pu_done;
  logic              busy;
  logic              fault_o;
  logic              lp_clk;
  logic              lp_tick;

  modport master (
    output en_i, fault_i, step_dly,
    input  pu_sig, pu_done, busy, fault_o, lp_clk, lp_tick
  );

  modport slave (
    input  en_i, fault_i, step_dly,
    output pu_sig, pu_done, busy, fault_o, lp_clk, lp_tick
  );
endinterface

// File: rtl/pu_sequencer_lp_clk_div.sv
// Low-power clock divider, enabled by channel 0 being powered.
//   clk, rst : system clock, async active-high reset
//   run      : divider runs while high; low clears everything on the next edge
//   lp_clk   : registered square wave, toggles on every tick
//   lp_tick  : one-cycle pulse, high while the count sits at LP_DIV-1
module lp_clk_div #(
  parameter int LP_DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic lp_clk,
  output logic lp_tick
);

  localparam int CW = (LP_DIV > 2) ? $clog2(LP_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LP_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(LP_DIV - 2);

  logic [CW-1:0] cnt_q;
  logic          lp_clk_q;
  logic          lp_tick_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      lp_clk_q  <= 1'b0;
      lp_tick_q <= 1'b0;
    end else if (!run) begin
      cnt_q     <= '0;
      lp_clk_q  <= 1'b0;
      lp_tick_q <= 1'b0;
    end else begin
      // tick is registered one count early so it lines up with cnt == LP_DIV-1
      lp_tick_q <= (cnt_q == CNT_PRE);
      if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        lp_clk_q <= ~lp_clk_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign lp_clk  = lp_clk_q;
  assign lp_tick = lp_tick_q;

endmodule

// File: rtl/pu_sequencer.sv
// Power-up sequencer: raises NUM_CH enables one per step in order ch0..chN-1,
// lowers them in reverse order, drops all at once on fault, and runs a
// low-power clock divider while channel 0 is up.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of pu_sequencer_if (requests in, status out)
//
// state | meaning
// IDLE  | all channels off, waiting for en_i (blocked while fault_o is set)
// UP    | raising channel idx when cnt reaches 1
// ON    | all channels up, pu_done high
// DOWN  | lowering channel idx (highest one up) when cnt reaches 1
module pu_sequencer
  import pu_seq_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEFAULT,
  parameter int DLY_W  = DLY_W_DEFAULT,
  parameter int LP_DIV = LP_DIV_DEFAULT
) (
  input logic           clk,
  input logic           rst,
  pu_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [DLY_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] pu_q, pu_d;
  logic              fault_q, fault_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DLY_W-1:0]  dly_load;
  logic [DLY_W-1:0]  cnt_dec;
  logic              step_evt;
  logic              lp_clk_w;
  logic              lp_tick_w;

  assign dly_load = DLY_W'(clamp_dly(32'(bus.step_dly)));
  assign step_evt = (cnt_q == DLY_W'(1));
  assign cnt_dec  = (cnt_q > DLY_W'(1)) ? (cnt_q - DLY_W'(1)) : DLY_W'(1);

  // Channels are always a contiguous run from ch0, so idx alone tracks
  // progress: in UP it is the next channel to raise, in DOWN/ON the
  // highest channel currently up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pu_d    = pu_q;
    fault_d = fault_q;

    if (!bus.fault_i && !bus.en_i) fault_d = 1'b0;

    if (bus.fault_i) begin
      state_d = IDLE;
      pu_d    = '0;
      idx_d   = '0;
      cnt_d   = '0;
      fault_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.en_i && !fault_q) begin
            state_d = UP;
            idx_d   = '0;
            cnt_d   = dly_load;
          end
        end
        UP: begin
          if (!bus.en_i) begin
            if (idx_q == '0) begin
              // nothing raised yet: no reverse sequence to run
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = DOWN;
              idx_d   = idx_q - IDX_W'(1);
              cnt_d   = dly_load;
            end
          end else if (step_evt) begin
            pu_d[idx_q] = 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d = ON;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              cnt_d = dly_load;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        ON: begin
          if (!bus.en_i) begin
            state_d = DOWN;
            cnt_d   = dly_load;
          end
        end
        DOWN: begin
          if (bus.en_i) begin
            if (idx_q == IDX_LAST) begin
              // every channel is still up, nothing left to raise
              state_d = ON;
            end else begin
              state_d = UP;
              idx_d   = idx_q + IDX_W'(1);
              cnt_d   = dly_load;
            end
          end else if (step_evt) begin
            pu_d[idx_q] = 1'b0;
            if (idx_q == '0) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              idx_d = idx_q - IDX_W'(1);
              cnt_d = dly_load;
            end
          end else begin
            cnt_d = cnt_dec;
          end
        end
        default: begin
          state_d = IDLE;
          pu_d    = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == UP) || (state_d == DOWN);
    done_d = (state_d == ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      pu_q    <= '0;
      fault_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pu_q    <= pu_d;
      fault_q <= fault_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  lp_clk_div #(
    .LP_DIV(LP_DIV)
  ) u_lp_clk_div (
    .clk    (clk),
    .rst    (rst),
    .run    (pu_q[0]),
    .lp_clk (lp_clk_w),
    .lp_tick(lp_tick_w)
  );

  assign bus.pu_sig  = pu_q;
  assign bus.pu_done = done_q;
  assign bus.busy    = busy_q;
  assign bus.fault_o = fault_q;
  assign bus.lp_clk  = lp_clk_w;
  assign bus.lp_tick = lp_tick_w;

endmodule

// File: tb/tb_pu_sequencer.sv
// Scoreboard bench for pu_sequencer: each driven cycle pushes the expected
// post-edge outputs from a channel-count/deadline model; a monitor pops and
// compares one entry per clock edge.
module tb_pu_sequencer;

  localparam int NUM_CH = 4;
  localparam int DLY_W  = 12;
  localparam int LP_DIV = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pu_sequencer_if #(.NUM_CH(NUM_CH), .DLY_W(DLY_W)) bus ();

  pu_sequencer #(
    .NUM_CH(NUM_CH),
    .DLY_W (DLY_W),
    .LP_DIV(LP_DIV)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint            t;
    logic [NUM_CH-1:0] pu;
    logic              done;
    logic              busy;
    logic              flt;
    logic              lpc;
    logic              lpt;
  } exp_t;

  typedef enum {M_OFF, M_RISING, M_FULL, M_FALLING} mmode_t;

  exp_t   sb_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  mmode_t mode;
  int     n_up;
  longint deadline;
  bit     m_flt;
  bit     prev_pu0;
  longint rise_t;
  longint t_edge = 0;

  function automatic longint dly(input int sd);
    return (sd == 0) ? 1 : sd;
  endfunction

  task automatic model_reset();
    mode     = M_OFF;
    n_up     = 0;
    deadline = 0;
    m_flt    = 1'b0;
    prev_pu0 = 1'b0;
    rise_t   = 0;
  endtask

  // Expected outputs right after the next clock edge given the inputs held there.
  task automatic model_edge(input bit en, input bit f, input int sd, output exp_t e);
    bit     flt_old;
    longint j;
    flt_old = m_flt;
    if (f) begin
      n_up  = 0;
      mode  = M_OFF;
      m_flt = 1'b1;
    end else begin
      if (!en) m_flt = 1'b0;
      case (mode)
        M_OFF: if (en && !flt_old) begin
          mode = M_RISING; deadline = t_edge + dly(sd);
        end
        M_RISING: begin
          if (!en) begin
            if (n_up == 0) mode = M_OFF;
            else begin mode = M_FALLING; deadline = t_edge + dly(sd); end
          end else if (t_edge == deadline) begin
            n_up++;
            if (n_up == NUM_CH) mode = M_FULL;
            else deadline = t_edge + dly(sd);
          end
        end
        M_FULL: if (!en) begin
          mode = M_FALLING; deadline = t_edge + dly(sd);
        end
        M_FALLING: begin
          if (en) begin
            if (n_up == NUM_CH) mode = M_FULL;
            else begin mode = M_RISING; deadline = t_edge + dly(sd); end
          end else if (t_edge == deadline) begin
            n_up--;
            if (n_up == 0) mode = M_OFF;
            else deadline = t_edge + dly(sd);
          end
        end
        default: mode = M_OFF;
      endcase
    end
    if (prev_pu0) begin
      j     = t_edge - rise_t;
      e.lpt = ((j % LP_DIV) == LP_DIV - 1);
      e.lpc = (((j / LP_DIV) % 2) == 1);
    end else begin
      e.lpt = 1'b0;
      e.lpc = 1'b0;
    end
    if (!prev_pu0 && n_up > 0) rise_t = t_edge;
    prev_pu0 = (n_up > 0);
    e.t    = t_edge;
    e.pu   = NUM_CH'((1 << n_up) - 1);
    e.done = (mode == M_FULL);
    e.busy = (mode == M_RISING) || (mode == M_FALLING);
    e.flt  = m_flt;
    t_edge++;
  endtask

  // Called 2 time units after a rising edge; returns at the same offset of the next.
  task automatic step(input bit en, input bit f, input int sd);
    exp_t e;
    bus.en_i     = en;
    bus.fault_i  = f;
    bus.step_dly = DLY_W'(sd);
    model_edge(en, f, sd, e);
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input bit en, input int sd, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, sd);
  endtask

  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        n_checks++;
        if (bus.pu_sig !== mon_e.pu || bus.pu_done !== mon_e.done ||
            bus.busy !== mon_e.busy || bus.fault_o !== mon_e.flt ||
            bus.lp_clk !== mon_e.lpc || bus.lp_tick !== mon_e.lpt) begin
          n_fail++;
          $display("FAIL outputs edge %0d: got pu=%b done=%b busy=%b flt=%b lpc=%b lpt=%b, want pu=%b done=%b busy=%b flt=%b lpc=%b lpt=%b",
                   mon_e.t, bus.pu_sig, bus.pu_done, bus.busy, bus.fault_o, bus.lp_clk, bus.lp_tick,
                   mon_e.pu, mon_e.done, mon_e.busy, mon_e.flt, mon_e.lpc, mon_e.lpt);
        end
      end
    end
  end

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({bus.pu_sig, bus.pu_done, bus.busy, bus.fault_o, bus.lp_clk, bus.lp_tick} !== '0) begin
      n_fail++;
      $display("FAIL %s: got pu=%b done=%b busy=%b flt=%b lpc=%b lpt=%b, want all zero",
               name, bus.pu_sig, bus.pu_done, bus.busy, bus.fault_o, bus.lp_clk, bus.lp_tick);
    end
  endtask

  bit en_r;
  int seg_len;
  int sd_r;

  initial begin
    bus.en_i     = 1'b0;
    bus.fault_i  = 1'b0;
    bus.step_dly = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset_state");
    rst = 1'b0;

    // full power-up with D=100, then power-down from ON
    hold(1'b1, 100, 500);
    hold(1'b0, 100, 450);

    // drop mid-UP, re-raise mid-DOWN, then finish the power-down
    hold(1'b1, 100, 250);
    hold(1'b0, 100, 150);
    hold(1'b1, 100, 150);
    hold(1'b0, 100, 300);

    // fault during UP, held request stays blocked, fresh request restarts
    hold(1'b1, 100, 150);
    step(1'b1, 1'b1, 100);
    hold(1'b1, 100, 100);
    hold(1'b0, 20, 5);
    hold(1'b1, 20, 120);
    hold(1'b0, 20, 100);

    // zero step delay: one-cycle steps, then async reset mid-UP
    hold(1'b1, 0, 2);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_mid_up");
    bus.en_i = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    model_reset();

    // randomized request segments with occasional faults and short delays
    en_r = 1'b0;
    for (int s = 0; s < 80; s++) begin
      en_r    = ~en_r;
      seg_len = $urandom_range(1, 150);
      for (int i = 0; i < seg_len; i++) begin
        sd_r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
        step(en_r, ($urandom_range(0, 299) == 0), sd_r);
      end
    end
    hold(1'b0, 1, 20);

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
